// File: rtl/neuron_accumulator.sv
// Frame accumulator for ternary synapse products with a thresholded 1-bit activation.
// Define FRACTAL_NN_SAT_EN for a saturating accumulator; otherwise it wraps.
module neuron_accumulator #(
  parameter int                      ACC_W     = 8,
  parameter int                      CNT_W     = 8,
  parameter logic signed [ACC_W-1:0] THRESHOLD = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              in_y,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_act,
  output logic signed [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0]        out_cnt,
  output logic                    out_ovf
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t                  state;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;
  logic                    ovf;

  logic signed [ACC_W-1:0] prod;
  logic [ACC_W:0]          sum_wide;
  logic                    add_ovf;
  logic signed [ACC_W-1:0] acc_nxt;
  logic [CNT_W-1:0]        cnt_nxt;
  logic                    ovf_nxt;
  logic                    act_nxt;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);

  always_comb begin
    prod = '0;
    case (in_y)
      2'b01:   prod = {{(ACC_W-1){1'b0}}, 1'b1};
      2'b11:   prod = '1;
      default: prod = '0;
    endcase
  end

  // One guard bit: overflow whenever the two top bits of the widened sum disagree.
  always_comb begin
    sum_wide = {acc[ACC_W-1], acc} + {prod[ACC_W-1], prod};
    add_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
`ifdef FRACTAL_NN_SAT_EN
    if (add_ovf)
      acc_nxt = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      acc_nxt = sum_wide[ACC_W-1:0];
`else
    acc_nxt = sum_wide[ACC_W-1:0];
`endif
    ovf_nxt = ovf | add_ovf;
    cnt_nxt = (&cnt) ? cnt : cnt + CNT_W'(1);
    act_nxt = (acc_nxt > THRESHOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ACCUM;
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      out_act <= 1'b0;
      out_sum <= '0;
      out_cnt <= '0;
      out_ovf <= 1'b0;
    end else if (clr) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
            ovf <= ovf_nxt;
            if (in_last) begin
              out_sum <= acc_nxt;
              out_act <= act_nxt;
              out_cnt <= cnt_nxt;
              out_ovf <= ovf_nxt;
              state   <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            state <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
